ppu_ctrl_pipeline: RTL
======================

// Module: ppu_ctrl_pipeline
// PURPOSE
//  Next-generation PPU control: combinational decode of the ID instruction into a CTRL_W-bit bundle, plus registered
//  control pipeline ID->EX->MEM->WB carrying bundle + destination register.
//  Adds load-use hazard detection, bubble insertion, global hold, branch flush and illegal-opcode flagging.
//  Sits between IF/ID register and datapath stage muxes.
// PARAMETERS
//  CTRL_W     22  bundle width; bits [21:0] fixed layout below, bits above 21 driven 0 (CTRL_W>=22)
//  HAZARD_EN  1   1: load-use detection active; 0: load_use_stall tied 0
//  RA_REG     31  destination index written by JAL
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high
//  id_instr        in   32      instruction in ID
//  id_valid        in   1       id_instr meaningful; 0 -> treated as NOP
//  hold            in   1       freeze all pipeline registers (memory wait)
//  flush_id        in   1       taken branch/jump: ID instruction becomes bubble
//  id_ctrl         out  CTRL_W  combinational decode of id_instr
//  ex_ctrl/mem_ctrl/wb_ctrl  out CTRL_W  registered bundles per stage
//  ex_dest/mem_dest/wb_dest  out 5       registered destination reg per stage (0 = none)
//  load_use_stall  out  1       combinational; upstream must hold PC and IF/ID when 1
//  ex_illegal      out  1       registered; 1 for the cycle an unknown opcode occupies EX
// BEHAVIOUR
//  Bundle bits: [21]uncond [20]r31 [19]jump [18]dest [17:15]src_op [14:11]alu_op [10]load [9]rf_en [8]branch [7]ta
//   [6:5]mem_size [4]mem_rw(1=write) [3]mem_se [2]hi_en [1]lo_en [0]mem_en; unlisted bits 0.
//  Decode (op / funct): ADDIU 001001: src=100 alu=0000 rf_en; dest=rt.
//   SUBU 000000/100011: src=000 alu=0001 rf_en; dest=rd.  JR 000000/001000: uncond,jump; dest=0.
//   LBU 100100: src=100 alu=0000 load,rf_en,mem_en,size=00; dest=rt.  SB 101000: src=100 mem_en,mem_rw,size=00; dest=0.
//   BGTZ 000111: alu=1010 branch,ta.  BGEZ 000001: alu=1001 branch.  BEQ/B 000100: alu=0001 branch.
//   JAL 000011: [21:18]=1111 src=011 alu=1100 rf_en; dest=RA_REG.  LUI 001111: src=101 alu=1011 rf_en; dest=rt.
//  id_instr==0, id_valid==0 or any X bit -> id_ctrl=0, dest=0, not illegal.
//  Other opcode/funct -> id_ctrl=0, dest=0, id_illegal=1 (internal).
//  rs-use: every listed op except JAL, LUI. rt-use: SUBU, SB, BEQ.
//  load_use_stall = HAZARD_EN & ex_ctrl[10] & ex_dest!=0 & id_valid &
//   ((rs-use & ex_dest==rs) | (rt-use & ex_dest==rt)).
//  Edge priority: reset > hold > advance.
//   reset: all *_ctrl, *_dest = 0, ex_illegal = 0 (also aborts in-flight ops; no partial state kept).
//   hold:  all stage registers keep value; load_use_stall still evaluated combinationally.
//   advance: wb<=mem, mem<=ex; EX <= bubble (ctrl 0, dest 0, illegal 0) if flush_id | load_use_stall,
//            else EX <= {id_ctrl, id_dest, id_illegal}.
//  flush_id and load_use_stall together -> single bubble (same result).
//  Latency: ID decode -> ex_ctrl 1 cycle, mem_ctrl 2, wb_ctrl 3 (absent hold/bubble).
//  Writes to r0: dest field forced 0 when decoded dest==0 (no hazard on $zero).
// STRUCTURE
//  ppu_ctrl_pkg: opcode/funct constants, bundle bit-index and field localparams, SRC_*/ALU_* encodings, CTRL_NOP.
//  Sub-module ppu_ctrl_decoder (combinational: instr -> ctrl, dest, rs/rt-use, illegal);
//   top holds three stage registers + hazard compare.
// TESTING
//  reset=1 2 cycles with random id_instr -> all outputs 0; reset released -> first ADDIU reaches ex_ctrl next edge.
//  ADDIU $5,$0,1 (0x24050001) then SUBU -> ex_ctrl src=100 rf_en, ex_dest=5; SUBU lands in mem/wb on schedule.
//  LBU $4,0($2) then ADDIU $6,$4,1 -> load_use_stall=1 one cycle, EX bubble, ADDIU enters EX after; with $6,$7 -> no stall.
//  LBU to $0 then use $0 -> no stall; JAL -> ex_dest=31, ex_ctrl[21:18]=1111.
//  hold=1 3 cycles mid-stream -> ex/mem/wb unchanged; flush_id with BGTZ in ID -> ex_ctrl=0 next edge.
//  opcode 111111 -> ex_illegal=1 exactly one cycle, ex_ctrl=0; instr 0 -> ex_illegal=0; reset during hold clears all.

Source files
------------

// File: rtl/ppu_ctrl_pkg.sv
// Shared definitions for the PPU control pipeline: opcode/funct values, the
// control bundle bit layout and the field encodings carried in it.
package ppu_ctrl_pkg;

  localparam int CTRL_BITS = 22;
  typedef logic [CTRL_BITS-1:0] ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;

  // Bundle bit indices
  localparam int B_UNCOND  = 21;
  localparam int B_R31     = 20;
  localparam int B_JUMP    = 19;
  localparam int B_DEST    = 18;
  localparam int SRC_HI    = 17;
  localparam int SRC_LO    = 15;
  localparam int ALU_HI    = 14;
  localparam int ALU_LO    = 11;
  localparam int B_LOAD    = 10;
  localparam int B_RF_EN   = 9;
  localparam int B_BRANCH  = 8;
  localparam int B_TA      = 7;
  localparam int SIZE_HI   = 6;
  localparam int SIZE_LO   = 5;
  localparam int B_MEM_RW  = 4;
  localparam int B_MEM_SE  = 3;
  localparam int B_HI_EN   = 2;
  localparam int B_LO_EN   = 1;
  localparam int B_MEM_EN  = 0;

  typedef enum logic [2:0] {
    SRC_REG  = 3'b000,
    SRC_LINK = 3'b011,
    SRC_IMM  = 3'b100,
    SRC_LUI  = 3'b101
  } src_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_GEZ  = 4'b1001,
    ALU_GTZ  = 4'b1010,
    ALU_LUI  = 4'b1011,
    ALU_LINK = 4'b1100
  } alu_op_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BGEZ    = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_SB      = 6'b101000;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  // Control state carried by the MEM and WB stage registers
  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] dest;
  } stage_t;

endpackage

// File: rtl/ppu_ctrl_if.sv
// ID-stage inputs and per-stage control outputs of the PPU control pipeline.
interface ppu_ctrl_if #(parameter int CTRL_W = 22);
  logic [31:0]       id_instr;
  logic              id_valid;
  logic              hold;
  logic              flush_id;
  logic [CTRL_W-1:0] id_ctrl;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [4:0]        ex_dest;
  logic [4:0]        mem_dest;
  logic [4:0]        wb_dest;
  logic              load_use_stall;
  logic              ex_illegal;

  modport master (
    output id_instr, id_valid, hold, flush_id,
    input  id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl,
    input  ex_dest, mem_dest, wb_dest, load_use_stall, ex_illegal
  );

  modport slave (
    input  id_instr, id_valid, hold, flush_id,
    output id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl,
    output ex_dest, mem_dest, wb_dest, load_use_stall, ex_illegal
  );
endinterface

// File: rtl/ppu_ctrl_decoder.sv
// Combinational ID decode: instruction -> control bundle, destination
// register, source-register usage and illegal-opcode flag.
module ppu_ctrl_decoder
  import ppu_ctrl_pkg::*;
#(
  parameter int RA_REG = 31
) (
  input  logic [31:0] instr,
  input  logic        valid,
  output ctrl_t       ctrl,
  output logic [4:0]  dest,
  output logic        rs_use,
  output logic        rt_use,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl    = CTRL_NOP;
    dest    = '0;
    rs_use  = 1'b0;
    rt_use  = 1'b0;
    illegal = 1'b0;

    // Bubbles, all-zero words and unresolved fetches decode as a silent NOP
    if (valid && instr != '0 && !$isunknown(instr)) begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_SUBU: begin
              ctrl[SRC_HI:SRC_LO] = SRC_REG;
              ctrl[ALU_HI:ALU_LO] = ALU_SUB;
              ctrl[B_RF_EN]       = 1'b1;
              dest                = rd;
              rs_use              = 1'b1;
              rt_use              = 1'b1;
            end
            FN_JR: begin
              ctrl[B_UNCOND] = 1'b1;
              ctrl[B_JUMP]   = 1'b1;
              rs_use         = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
        OP_ADDIU: begin
          ctrl[SRC_HI:SRC_LO] = SRC_IMM;
          ctrl[ALU_HI:ALU_LO] = ALU_ADD;
          ctrl[B_RF_EN]       = 1'b1;
          dest                = rt;
          rs_use              = 1'b1;
        end
        OP_LBU: begin
          ctrl[SRC_HI:SRC_LO]   = SRC_IMM;
          ctrl[ALU_HI:ALU_LO]   = ALU_ADD;
          ctrl[B_LOAD]          = 1'b1;
          ctrl[B_RF_EN]         = 1'b1;
          ctrl[B_MEM_EN]        = 1'b1;
          ctrl[SIZE_HI:SIZE_LO] = SIZE_BYTE;
          dest                  = rt;
          rs_use                = 1'b1;
        end
        OP_SB: begin
          ctrl[SRC_HI:SRC_LO]   = SRC_IMM;
          ctrl[B_MEM_EN]        = 1'b1;
          ctrl[B_MEM_RW]        = 1'b1;
          ctrl[SIZE_HI:SIZE_LO] = SIZE_BYTE;
          rs_use                = 1'b1;
          rt_use                = 1'b1;
        end
        OP_BGTZ: begin
          ctrl[ALU_HI:ALU_LO] = ALU_GTZ;
          ctrl[B_BRANCH]      = 1'b1;
          ctrl[B_TA]          = 1'b1;
          rs_use              = 1'b1;
        end
        OP_BGEZ: begin
          ctrl[ALU_HI:ALU_LO] = ALU_GEZ;
          ctrl[B_BRANCH]      = 1'b1;
          rs_use              = 1'b1;
        end
        OP_BEQ: begin
          ctrl[ALU_HI:ALU_LO] = ALU_SUB;
          ctrl[B_BRANCH]      = 1'b1;
          rs_use              = 1'b1;
          rt_use              = 1'b1;
        end
        OP_JAL: begin
          ctrl[B_UNCOND]      = 1'b1;
          ctrl[B_R31]         = 1'b1;
          ctrl[B_JUMP]        = 1'b1;
          ctrl[B_DEST]        = 1'b1;
          ctrl[SRC_HI:SRC_LO] = SRC_LINK;
          ctrl[ALU_HI:ALU_LO] = ALU_LINK;
          ctrl[B_RF_EN]       = 1'b1;
          dest                = 5'(RA_REG);
        end
        OP_LUI: begin
          ctrl[SRC_HI:SRC_LO] = SRC_LUI;
          ctrl[ALU_HI:ALU_LO] = ALU_LUI;
          ctrl[B_RF_EN]       = 1'b1;
          dest                = rt;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ppu_ctrl_pipeline.sv
// PPU control pipeline: ID decode plus registered ID->EX->MEM->WB control
// bundles with load-use stall, branch flush bubbles and global hold.
module ppu_ctrl_pipeline
  import ppu_ctrl_pkg::*;
#(
  parameter int CTRL_W    = 22,
  parameter bit HAZARD_EN = 1'b1,
  parameter int RA_REG    = 31
) (
  input  logic       clk,
  input  logic       reset,
  ppu_ctrl_if.slave  bus
);

  ctrl_t      id_ctrl;
  logic [4:0] id_dest;
  logic       id_rs_use;
  logic       id_rt_use;
  logic       id_illegal;

  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  logic   ex_illegal_q;
  logic   load_use;
  logic   bubble;

  ppu_ctrl_decoder #(.RA_REG(RA_REG)) u_decoder (
    .instr   (bus.id_instr),
    .valid   (bus.id_valid),
    .ctrl    (id_ctrl),
    .dest    (id_dest),
    .rs_use  (id_rs_use),
    .rt_use  (id_rt_use),
    .illegal (id_illegal)
  );

  // A load in EX whose result the ID instruction reads; $zero never matches
  // because a load targeting r0 carries dest 0.
  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN && ex_q.ctrl[B_LOAD] && ex_q.dest != '0 && bus.id_valid) begin
      load_use = (id_rs_use && ex_q.dest == bus.id_instr[25:21]) ||
                 (id_rt_use && ex_q.dest == bus.id_instr[20:16]);
    end
  end

  assign bubble = bus.flush_id | load_use;

  // NOTE: stage registers use non-blocking assignments so every stage samples
  // its upstream neighbour's pre-edge value, giving a true shift each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      ex_illegal_q <= 1'b0;
    end else if (!bus.hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q         <= '0;
        ex_illegal_q <= 1'b0;
      end else begin
        ex_q         <= '{ctrl: id_ctrl, dest: id_dest};
        ex_illegal_q <= id_illegal;
      end
    end
  end

  // Bundle bits above the fixed layout are zero-extended
  assign bus.id_ctrl        = CTRL_W'(id_ctrl);
  assign bus.ex_ctrl        = CTRL_W'(ex_q.ctrl);
  assign bus.mem_ctrl       = CTRL_W'(mem_q.ctrl);
  assign bus.wb_ctrl        = CTRL_W'(wb_q.ctrl);
  assign bus.ex_dest        = ex_q.dest;
  assign bus.mem_dest       = mem_q.dest;
  assign bus.wb_dest        = wb_q.dest;
  assign bus.load_use_stall = load_use;
  assign bus.ex_illegal     = ex_illegal_q;

endmodule
